// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: decodes one 24-bit GRB pixel into CPU-readable registers.
// Define WS2812_RX_PASSTHRU_EN to repeat pixels after the first one on dout.
module ws2812_rx #(
  parameter int CLK_FRE    = 25_175_000,
  parameter int BIT_THRESH = 15,
  parameter int MIN_HIGH   = 3,
  parameter int MAX_HIGH   = 50,
  parameter int RESET_CYC  = 1259
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       din,
  input  logic       rx_cs,
  input  logic       wr_n,
  input  logic [1:0] reg_addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       frame_o,
  output logic       dout
);

  localparam int CNT_MAX = (RESET_CYC > MAX_HIGH) ? RESET_CYC : MAX_HIGH;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);

  localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] RST_LAST_C = CNT_W'(RESET_CYC - 1);
  localparam logic [31:0]      CLK_FRE_W  = 32'(CLK_FRE);
  localparam logic [4:0]       FULL       = 5'd24;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic             din_s1_q, din_s2_q, din_prev_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [23:0]      shadow_q, shadow_d;
  logic [7:0]       r_q, g_q, b_q;
  logic             valid_q, valid_d, err_q, err_d, frame_q;
  logic             rise, fall, sts_wr, commit, set_err, enter_err;
  logic             unused_cfg;

  assign rise   = din_s2_q & ~din_prev_q;
  assign fall   = ~din_s2_q & din_prev_q;
  assign sts_wr = rx_cs & ~wr_n & (reg_addr_i == 2'b00);
  // Upper write-data bits and the clock frequency do not affect the logic.
  assign unused_cfg = ^{data_i[7:2], CLK_FRE_W};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shadow_d  = shadow_q;
    commit    = 1'b0;
    set_err   = 1'b0;
    enter_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          cnt_d   = '0;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q > MAX_C) begin
          enter_err = 1'b1;
        end else if (fall) begin
          if (cnt_q < MIN_C) begin
            enter_err = 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = ST_LOW;
            if (bit_cnt_q < FULL) begin
              shadow_d  = {shadow_q[22:0], (cnt_q >= THRESH_C)};
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      ST_LOW: begin
        cnt_d = cnt_q + 1'b1;
        if (rise) begin
          cnt_d   = '0;
          state_d = ST_HIGH;
        end else if (cnt_q >= RST_LAST_C) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          bit_cnt_d = '0;
          shadow_d  = '0;
          commit    = (bit_cnt_q == FULL);
          set_err   = (bit_cnt_q != FULL) && (bit_cnt_q != 5'd0);
        end
      end
      default: begin
        // Any high level restarts the required quiet period.
        if (din_s2_q) begin
          cnt_d = '0;
        end else if (cnt_q >= RST_LAST_C) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    if (enter_err) begin
      state_d   = ST_ERR;
      cnt_d     = '0;
      bit_cnt_d = '0;
      shadow_d  = '0;
      set_err   = 1'b1;
    end
  end

  // Set events take priority over write-1-to-clear.
  assign valid_d = (valid_q & ~(sts_wr & data_i[0])) | commit;
  assign err_d   = (err_q & ~(sts_wr & data_i[1])) | set_err;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      din_s1_q   <= 1'b0;
      din_s2_q   <= 1'b0;
      din_prev_q <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shadow_q   <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      din_s1_q   <= din;
      din_s2_q   <= din_s1_q;
      din_prev_q <= din_s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shadow_q   <= shadow_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      frame_q    <= commit;
      if (commit) begin
        g_q <= shadow_q[23:16];
        r_q <= shadow_q[15:8];
        b_q <= shadow_q[7:0];
      end
    end
  end

  always_comb begin
    case (reg_addr_i)
      2'b00:   data_o = {(state_q != ST_IDLE), 5'b0, err_q, valid_q};
      2'b01:   data_o = r_q;
      2'b10:   data_o = g_q;
      default: data_o = b_q;
    endcase
  end

  assign frame_o = frame_q;

`ifdef WS2812_RX_PASSTHRU_EN
  logic dout_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dout_q <= 1'b0;
    end else begin
      dout_q <= din_s2_q & (bit_cnt_q == FULL) &
                ((state_q == ST_HIGH) | (state_q == ST_LOW));
    end
  end
  assign dout = dout_q;
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: table of frames plus hand-written corner sequences.
module tb_ws2812_rx;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       din = 1'b0;
  logic       rx_cs = 1'b0;
  logic       wr_n = 1'b1;
  logic [1:0] reg_addr_i = 2'b00;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic       frame_o;
  logic       dout;

  ws2812_rx dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .din(din), .rx_cs(rx_cs), .wr_n(wr_n),
    .reg_addr_i(reg_addr_i), .data_i(data_i), .data_o(data_o),
    .frame_o(frame_o), .dout(dout)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int frame_cnt = 0;
  always @(negedge clk_i) if (frame_o) frame_cnt++;

  logic din_log  [0:4095];
  logic dout_log [0:4095];
  int   log_n = 0;

  typedef struct {
    int          nbits;
    logic [47:0] data;
    logic        clr;
    logic [7:0]  g, r, b, st;
    int          frames;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive din, wait for the edge, sample 1 ns later.
  task automatic cyc(input logic v);
    din = v;
    if (log_n < 4096) din_log[log_n] = v;
    @(posedge clk_i);
    #1;
    if (log_n < 4096) begin
      dout_log[log_n] = dout;
      log_n++;
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    reg_addr_i = a;
    rx_cs = 1'b0;
    #1;
    v = data_o;
  endtask

  task automatic wr_status(input logic [7:0] v);
    reg_addr_i = 2'b00; data_i = v; rx_cs = 1'b1; wr_n = 1'b0;
    cyc(1'b0);
    rx_cs = 1'b0; wr_n = 1'b1; data_i = 8'h00;
  endtask

  task automatic send_bits(input logic [47:0] data, input int nbits);
    for (int b = nbits - 1; b >= 0; b--) begin
      int h;
      h = data[b] ? 34 : 10;
      for (int k = 0; k < h; k++) cyc(1'b1);
      for (int k = h; k < 50; k++) cyc(1'b0);
    end
  endtask

  task automatic hold_low(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0);
  endtask

  task automatic chk_regs(input string tag, input logic [7:0] g, input logic [7:0] r,
                          input logic [7:0] b, input logic [7:0] st);
    logic [7:0] v;
    rd(2'b10, v); chk({tag, "_g"}, int'(v), int'(g));
    rd(2'b01, v); chk({tag, "_r"}, int'(v), int'(r));
    rd(2'b11, v); chk({tag, "_b"}, int'(v), int'(b));
    rd(2'b00, v); chk({tag, "_status"}, int'(v), int'(st));
  endtask

  initial begin
    logic [7:0] v;
    int f0, k_wr, mism, hi_cnt, exp_hi, k_frame;
    logic [47:0] pix;

    vecs[0] = '{24, 48'hFF8001,        1'b1, 8'hFF, 8'h80, 8'h01, 8'h01, 1};
    vecs[1] = '{24, 48'h00FF55,        1'b1, 8'h00, 8'hFF, 8'h55, 8'h01, 1};
    vecs[2] = '{12, 48'hABC,           1'b1, 8'h00, 8'hFF, 8'h55, 8'h02, 0};
    vecs[3] = '{24, 48'h123456,        1'b0, 8'h12, 8'h34, 8'h56, 8'h03, 1};
    vecs[4] = '{48, 48'hA5A5A5_123456, 1'b1, 8'hA5, 8'hA5, 8'hA5, 8'h01, 1};
    vecs[5] = '{0,  48'h0,             1'b1, 8'hA5, 8'hA5, 8'hA5, 8'h00, 0};

    repeat (3) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    cyc(1'b0);

    chk_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("reset_frame_o", int'(frame_o), 0);
    chk("reset_dout", int'(dout), 0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].clr) wr_status(8'h03);
      f0 = frame_cnt;
      log_n = 0;
      send_bits(vecs[i].data, vecs[i].nbits);
      hold_low(1300);
      chk_regs($sformatf("vec%0d", i), vecs[i].g, vecs[i].r, vecs[i].b, vecs[i].st);
      chk($sformatf("vec%0d_frames", i), frame_cnt - f0, vecs[i].frames);
      if (vecs[i].nbits == 48) begin
        // Repeater: dout sampled two ticks later mirrors din once the first pixel is full.
        mism = 0;
        hi_cnt = 0;
        for (int t = 0; t + 2 < log_n; t++) begin
          logic e;
`ifdef WS2812_RX_PASSTHRU_EN
          e = (t >= 24 * 50) ? din_log[t] : 1'b0;
`else
          e = 1'b0;
`endif
          if (dout_log[t + 2] !== e) mism++;
          if (dout_log[t + 2] === 1'b1) hi_cnt++;
        end
        exp_hi = 0;
`ifdef WS2812_RX_PASSTHRU_EN
        pix = vecs[i].data;
        for (int b = 0; b < 24; b++) exp_hi += pix[b] ? 34 : 10;
`endif
        chk("passthru_mismatch_cycles", mism, 0);
        chk("passthru_high_cycles", hi_cnt, exp_hi);
      end
      rd(2'b00, v);
      $display("vec %0d: nbits=%0d data=%012h status=%02h frames=%0d",
               i, vecs[i].nbits, vecs[i].data, v, frame_cnt - f0);
    end

    // Glitch mid-frame: error state, then recovery after a quiet period.
    wr_status(8'h03);
    send_bits(48'h15, 5);
    cyc(1'b1); cyc(1'b1);
    hold_low(8);
    rd(2'b00, v); chk("glitch_busy_status", int'(v), 'h82);
    hold_low(1300);
    rd(2'b00, v); chk("glitch_idle_status", int'(v), 'h02);
    f0 = frame_cnt;
    send_bits(48'h0F0E0D, 24);
    hold_low(1300);
    chk_regs("after_glitch", 8'h0F, 8'h0E, 8'h0D, 8'h03);
    chk("after_glitch_frames", frame_cnt - f0, 1);
    $display("glitch sequence: status=%02h", v);

    // Clear write landing on the commit edge: set must win.
    wr_status(8'h03);
    f0 = frame_cnt;
    send_bits(48'h010203, 24);
    k_wr = 1261 - 16;
    k_frame = 0;
    for (int k = 0; k < 1300; k++) begin
      if (k == k_wr) begin
        reg_addr_i = 2'b00; data_i = 8'h01; rx_cs = 1'b1; wr_n = 1'b0;
      end
      cyc(1'b0);
      if (k == k_wr) begin
        k_frame = int'(frame_o);
        rx_cs = 1'b0; wr_n = 1'b1; data_i = 8'h00;
      end
    end
    chk("collide_commit_cycle", k_frame, 1);
    chk("collide_frames", frame_cnt - f0, 1);
    chk_regs("collide", 8'h01, 8'h02, 8'h03, 8'h01);
    wr_status(8'h03);
    rd(2'b00, v); chk("w1c_both", int'(v), 'h00);
    $display("collision sequence: status after clear=%02h", v);

    // Asynchronous reset mid-frame.
    send_bits(48'h2AA, 10);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk_regs("midreset", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("midreset_frame_o", int'(frame_o), 0);
    chk("midreset_dout", int'(dout), 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    cyc(1'b0);
    f0 = frame_cnt;
    send_bits(48'hC35AE7, 24);
    hold_low(1300);
    chk_regs("post_reset", 8'hC3, 8'h5A, 8'hE7, 8'h01);
    chk("post_reset_frames", frame_cnt - f0, 1);
    $display("reset sequence: frames=%0d", frame_cnt - f0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
